// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART definitions (tx state encoding, data width)
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous byte FIFO, wrap-bit pointers for full/empty
module uart_tx_fifo #(
    parameter int depth = 4,
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [width-1:0] in_tdata,
    input  logic             in_tvalid,
    output logic             in_tready,
    output logic [width-1:0] out_tdata,
    output logic             out_tvalid,
    input  logic             out_tready
);

    localparam int AW = $clog2(depth);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [width-1:0] mem_q [depth];
    logic             full, empty, push, pop;

    // Same index with differing wrap bits means the writer lapped the reader.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign push       = in_tvalid && !full;
    assign pop        = out_tready && !empty;
    assign in_tready  = !full;
    assign out_tvalid = !empty;
    assign out_tdata  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_tdata;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8N1 UART transmitter; UART_TX_FIFO_EN adds an input byte FIFO
module uart_tx
    import uart_pkg::*;
#(
    parameter int clocks_per_bit = 4,
    parameter int stop_bits      = 1,
    parameter int fifo_depth     = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       out_ready,
    output logic       out_serial,
    output logic       out_busy
);

    localparam int CW = $clog2(clocks_per_bit);
    localparam int IW = $clog2(UART_DATA_BITS);

    if (clocks_per_bit < 2 || stop_bits < 1 || stop_bits > 2 || fifo_depth < 2 ||
        (fifo_depth & (fifo_depth - 1)) != 0) begin : g_bad_param
        $error("uart_tx: illegal parameter value");
    end

    tx_state_e                 state_q, state_d;
    logic [CW-1:0]             cycle_count_q, cycle_count_d;
    logic [IW-1:0]             bit_index_q, bit_index_d;
    logic                      stop_index_q, stop_index_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      out_serial_q, out_serial_d;

    logic                      bit_end, last_stop, can_load, load, src_valid;
    logic [7:0]                src_data;

    assign bit_end   = (cycle_count_q == CW'(clocks_per_bit - 1));
    assign last_stop = (state_q == STOP) && bit_end && (stop_index_q == 1'(stop_bits - 1));
    // The final stop cycle doubles as a load slot so frames can run gapless.
    assign can_load  = (state_q == IDLE) || last_stop;
    assign load      = can_load && src_valid;

`ifdef UART_TX_FIFO_EN
    logic fifo_in_ready;

    uart_tx_fifo #(
        .depth (fifo_depth),
        .width (UART_DATA_BITS)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .in_tdata   (in_data),
        .in_tvalid  (in_valid),
        .in_tready  (fifo_in_ready),
        .out_tdata  (src_data),
        .out_tvalid (src_valid),
        .out_tready (can_load)
    );

    assign out_ready = fifo_in_ready;
    assign out_busy  = (state_q != IDLE) || src_valid;
`else
    assign src_valid = in_valid;
    assign src_data  = in_data;
    assign out_ready = can_load;
    assign out_busy  = (state_q != IDLE);
`endif

    assign out_serial = out_serial_q;

    always_comb begin
        state_d       = state_q;
        cycle_count_d = bit_end ? '0 : cycle_count_q + CW'(1);
        bit_index_d   = bit_index_q;
        stop_index_d  = stop_index_q;
        shift_d       = shift_q;
        out_serial_d  = 1'b1;
        case (state_q)
            IDLE: begin
                cycle_count_d = '0;
                if (load) begin
                    state_d = START;
                    shift_d = src_data;
                end
            end
            START: begin
                out_serial_d = 1'b0;
                if (bit_end) begin
                    state_d     = DATA;
                    bit_index_d = '0;
                end
            end
            DATA: begin
                out_serial_d = shift_q[0];
                if (bit_end) begin
                    shift_d     = shift_q >> 1;
                    bit_index_d = bit_index_q + IW'(1);
                    if (bit_index_q == IW'(UART_DATA_BITS - 1)) begin
                        state_d      = STOP;
                        stop_index_d = 1'b0;
                    end
                end
            end
            STOP: begin
                out_serial_d = 1'b1;
                if (last_stop) begin
                    if (load) begin
                        state_d = START;
                        shift_d = src_data;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (bit_end) begin
                    stop_index_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            cycle_count_q <= '0;
            bit_index_q   <= '0;
            stop_index_q  <= 1'b0;
            shift_q       <= '0;
            out_serial_q  <= 1'b1;
        end else begin
            state_q       <= state_d;
            cycle_count_q <= cycle_count_d;
            bit_index_q   <= bit_index_d;
            stop_index_q  <= stop_index_d;
            shift_q       <= shift_d;
            out_serial_q  <= out_serial_d;
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx (default build or UART_TX_FIFO_EN)
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int SB    = 1;
    localparam int DEPTH = 4;
    localparam int F     = (9 + SB) * CPB;
`ifdef UART_TX_FIFO_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       out_ready, out_serial, out_busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int acc_cnt = 0;
    int acc_edge = 0;

    typedef struct {
        int         a;
        int         p;
        logic [7:0] d;
    } frame_t;

    frame_t     frames[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_rx[$];

    always #5 clk = ~clk;

    uart_tx #(
        .clocks_per_bit (CPB),
        .stop_bits      (SB),
        .fifo_depth     (DEPTH)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_ready  (out_ready),
        .out_serial (out_serial),
        .out_busy   (out_busy)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    function automatic int last_end();
        if (frames.size() == 0) return 0;
        return frames[frames.size() - 1].p + F;
    endfunction

    // Frame loaded at edge p drives the line over edges p+1 .. p+F.
    function automatic logic exp_serial(input int u);
        foreach (frames[i]) begin
            if (u >= frames[i].p + 1 && u < frames[i].p + 1 + F) begin
                int k;
                k = (u - frames[i].p - 1) / CPB;
                if (k == 0) return 1'b0;
                if (k <= 8) return frames[i].d[k-1];
                return 1'b1;
            end
        end
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input int u);
        foreach (frames[i]) begin
            if (u >= frames[i].a && u < frames[i].p + F) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic exp_ready(input int u);
`ifdef UART_TX_FIFO_EN
        int n;
        n = 0;
        foreach (frames[i]) begin
            if (u >= frames[i].a && u < frames[i].p) n++;
        end
        return n < DEPTH;
`else
        return u >= last_end() - 1;
`endif
    endfunction

    always @(posedge clk) begin
        int u;
        u = cyc + 1;
        cyc <= u;
        if (resetn && in_valid && out_ready) begin
            frame_t f;
            f.a = u;
            f.d = in_data;
`ifdef UART_TX_FIFO_EN
            f.p = (u + 1 > last_end()) ? u + 1 : last_end();
`else
            f.p = u;
`endif
            frames.push_back(f);
            acc_cnt  <= acc_cnt + 1;
            acc_edge <= u;
        end
    end

    always @(negedge resetn) frames.delete();

    always @(negedge clk) begin
        chk("line", out_serial, exp_serial(cyc));
        chk("ready", out_ready, exp_ready(cyc));
        chk("busy", out_busy, exp_busy(cyc));
    end

    // Independent mid-bit sampler, as a receiver on the far end would see the line.
    always @(negedge clk) begin : rx_dec
        int         cnt;
        int         k;
        bit         act;
        logic [7:0] sh;
        if (!resetn) begin
            act = 1'b0;
        end else begin
            if (!act && !out_serial) begin
                act = 1'b1;
                cnt = 0;
            end else if (act) begin
                cnt++;
            end
            if (act && (cnt % CPB) == CPB / 2) begin
                k = cnt / CPB;
                if (k >= 1 && k <= 8) sh[k-1] = out_serial;
                if (k == 9) begin
                    rx_q.push_back(sh);
                    act = 1'b0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [7:0] b, input bit keep);
        int n0;
        n0 = acc_cnt;
        in_data  = b;
        in_valid = 1'b1;
        for (int i = 0; i < 1000 && acc_cnt == n0; i++) step();
        chk("send_accept", acc_cnt - n0, 1);
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000 && out_busy; i++) step();
        chk("idle_timeout", out_busy, 0);
        repeat (4) step();
    endtask

    initial begin
        logic [39:0] cap;
        int          nbusy;
        int          a1;
        logic [7:0]  t3 [5];

        // Reset and idle
        resetn = 1'b0;
        repeat (3) step();
        resetn = 1'b1;
        #1;
        chk("rst_ready", out_ready, 1);
        chk("rst_line", out_serial, 1);
        chk("rst_busy", out_busy, 0);
        repeat (20) step();
        chk("idle_line", out_serial, 1);
        chk("idle_ready", out_ready, 1);
        chk("idle_busy", out_busy, 0);

        // Single byte 0xA5, literal waveform
        send(8'hA5, 1'b0);
        exp_rx.push_back(8'hA5);
        cap   = '0;
        nbusy = 0;
        for (int i = 0; i < 46; i++) begin
            @(negedge clk);
            if (out_busy) nbusy++;
            if (i >= LAT && i < LAT + 40) cap = {cap[38:0], out_serial};
        end
        chk("a5_wave", cap, 40'h0F0F00F0FF);
`ifdef UART_TX_FIFO_EN
        chk("a5_busy_cycles", nbusy, 41);
`else
        chk("a5_busy_cycles", nbusy, 40);
`endif
        wait_idle();

        // Assorted bytes, producer drops valid between them
        t3 = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h0F};
        foreach (t3[i]) begin
            send(t3[i], 1'b0);
            exp_rx.push_back(t3[i]);
        end
        wait_idle();

        // Valid held high: frames must follow with no idle gap
        send(8'h11, 1'b1);
        a1 = acc_edge;
        send(8'h22, 1'b1);
`ifdef UART_TX_FIFO_EN
        chk("b2b_spacing", acc_edge - a1, 1);
`else
        chk("b2b_spacing", acc_edge - a1, 40);
`endif
        send(8'h33, 1'b0);
        exp_rx.push_back(8'h11);
        exp_rx.push_back(8'h22);
        exp_rx.push_back(8'h33);
        wait_idle();

`ifdef UART_TX_FIFO_EN
        // Six bytes offered at once: serialiser plus full FIFO holds five
        for (int i = 0; i < 6; i++) begin
            send(8'h60 + 8'(i), 1'b1);
            exp_rx.push_back(8'h60 + 8'(i));
            if (i == 4) chk("fifo_full_ready", out_ready, 0);
        end
        in_valid = 1'b0;
        wait_idle();
`endif

        // Reset during data bit 3 of 0xF0 (bit 3 is low)
        send(8'hF0, 1'b0);
        repeat (LAT + 4 * CPB + 1) step();
        chk("pre_reset_line", out_serial, 0);
        resetn = 1'b0;
        #1;
        chk("abort_line", out_serial, 1);
        chk("abort_busy", out_busy, 0);
        repeat (2) step();
        resetn = 1'b1;
        #1;
        chk("post_rst_ready", out_ready, 1);
        send(8'h3C, 1'b0);
        exp_rx.push_back(8'h3C);
        wait_idle();

        chk("rx_count", rx_q.size(), exp_rx.size());
        foreach (exp_rx[i]) begin
            if (i < rx_q.size()) chk("rx_byte", rx_q[i], exp_rx[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1);
    end

endmodule
